// File: rtl/z2_bus_sequencer.sv
// Zorro II slave-cycle front end: strobe synchronisers, the four-state
// cycle sequencer, registered dtack collection and a bus-timeout watchdog.
module z2_bus_sequencer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       MEMCLK,
    input  logic       RESET,
    input  logic       AS_n,
    input  logic       UDS_n,
    input  logic       LDS_n,
    input  logic       RW,
    input  logic [4:0] sel,
    input  logic [4:0] ack,
    output logic       as_sync,
    output logic       uds_sync,
    output logic       lds_sync,
    output logic       rw_sync,
    output logic [1:0] z2_state,
    output logic [4:0] cycle_target,
    output logic       dtack,
    output logic       timeout
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_START = 2'b01,
        ST_DATA  = 2'b10,
        ST_END   = 2'b11
    } state_t;

    // Counter value on which the watchdog gives up while still in DATA.
    localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    // Handshake: a target raises ack[n] while it is the latched cycle_target
    // and the sequencer is in DATA; dtack rises on the next edge and stays
    // high until the master releases AS, regardless of when ack drops.

    logic [2:0] r_as_sync;
    logic [1:0] r_uds_sync;
    logic [1:0] r_lds_sync;
    logic [1:0] r_rw_sync;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [4:0] r_target;
    logic [4:0] w_target_nxt;
    logic [4:0] w_prio;
    logic       r_dtack;
    logic       w_dtack_nxt;
    logic       r_timeout;
    logic       w_timeout_nxt;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nxt;
    logic [7:0] w_cnt_inc;

    // Shift the raw asynchronous strobes into MEMCLK; bit 0 is the first stage.
    always_ff @(posedge MEMCLK or posedge RESET) begin
        if (RESET) begin
            r_as_sync  <= 3'b111;
            r_uds_sync <= 2'b11;
            r_lds_sync <= 2'b11;
            r_rw_sync  <= 2'b11;
        end else begin
            r_as_sync  <= {r_as_sync[1:0], AS_n};
            r_uds_sync <= {r_uds_sync[0], UDS_n};
            r_lds_sync <= {r_lds_sync[0], LDS_n};
            r_rw_sync  <= {r_rw_sync[0], RW};
        end
    end

    // Pick one target from the decode: ctrl > ram > ide > autoconfig > flash.
    always_comb begin
        w_prio = 5'b00000;
        if (sel[0])      w_prio = 5'b00001;
        else if (sel[1]) w_prio = 5'b00010;
        else if (sel[2]) w_prio = 5'b00100;
        else if (sel[3]) w_prio = 5'b01000;
        else if (sel[4]) w_prio = 5'b10000;
    end

    // Watchdog counter saturates so it can never wrap back below the limit.
    assign w_cnt_inc = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;

    // Next-state and registered-output logic for the cycle sequencer.
    always_comb begin
        w_state_nxt   = r_state;
        w_target_nxt  = r_target;
        w_dtack_nxt   = r_dtack;
        w_timeout_nxt = 1'b0;
        w_cnt_nxt     = r_cnt;
        case (r_state)
            ST_IDLE: begin
                w_dtack_nxt = 1'b0;
                w_cnt_nxt   = 8'd0;
                if (!r_as_sync[2] && (sel != 5'b00000)) begin
                    w_target_nxt = w_prio;
                    w_state_nxt  = ST_START;
                end
            end
            ST_START: begin
                w_cnt_nxt = w_cnt_inc;
                if (!r_uds_sync[1] || !r_lds_sync[1]) begin
                    w_state_nxt = ST_DATA;
                end else if (r_as_sync[1]) begin
                    w_state_nxt  = ST_IDLE;
                    w_target_nxt = 5'b00000;
                end
            end
            ST_DATA: begin
                w_cnt_nxt = w_cnt_inc;
                if ((ack & r_target) != 5'b00000) begin
                    w_dtack_nxt = 1'b1;
                    w_state_nxt = ST_END;
                end else if (r_as_sync[1]) begin
                    w_dtack_nxt  = 1'b0;
                    w_target_nxt = 5'b00000;
                    w_state_nxt  = ST_IDLE;
                end else if (r_cnt == LP_CNT_LAST) begin
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = ST_END;
                end
            end
            ST_END: begin
                if (r_as_sync[1]) begin
                    w_dtack_nxt  = 1'b0;
                    w_target_nxt = 5'b00000;
                    w_state_nxt  = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge MEMCLK or posedge RESET) begin
        if (RESET) begin
            r_state   <= ST_IDLE;
            r_target  <= 5'b00000;
            r_dtack   <= 1'b0;
            r_timeout <= 1'b0;
            r_cnt     <= 8'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_target  <= w_target_nxt;
            r_dtack   <= w_dtack_nxt;
            r_timeout <= w_timeout_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    assign as_sync      = r_as_sync[1];
    assign uds_sync     = r_uds_sync[1];
    assign lds_sync     = r_lds_sync[1];
    assign rw_sync      = r_rw_sync[1];
    assign z2_state     = r_state;
    assign cycle_target = r_target;
    assign dtack        = r_dtack;
    assign timeout      = r_timeout;

endmodule
